// File: rtl/ifetch_unit.sv
// ============================================================================
// ifetch_unit -- instruction fetch front end
//
// Owns the program counter and issues halfword reads to instruction memory.
// Each returned 16-bit instruction is buffered, together with its address, in
// a small prefetch FIFO. The decoder takes instructions from the head of that
// FIFO through a valid/ready handshake. A branch redirect flushes the FIFO and
// restarts fetch at the new PC. If a read is still outstanding when the
// redirect arrives, its returning data is dropped.
//
// Parameters
//   ADDR_W    instruction byte-address width (bit 0 of every fetch address is 0)
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk             in   clock; all state changes on the rising edge
//   reset           in   asynchronous active-low reset
//   imem_req        out  read request, held until imem_ack
//   imem_addr       out  read address, stable while imem_req is high
//   imem_ack        in   read complete this cycle (ignored when imem_req = 0)
//   imem_rdata      in   returned instruction halfword
//   instr_valid     out  FIFO head holds an instruction
//   instruction     out  FIFO head instruction (0 when empty)
//   instr_pc        out  address of the FIFO head instruction (0 when empty)
//   instr_ready     in   decoder accepts the head when instr_valid is high
//   redirect_valid  in   branch taken / PC load
//   redirect_pc     in   new fetch address (bit 0 is forced to 0)
// ============================================================================
module ifetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // IDLE: no read outstanding.
    // REQ:  a read is outstanding and its data is wanted.
    // DROP: a read is outstanding and its data must be discarded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_fetch_pc;

    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [15:0]         r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_pc    [DEPTH];

    logic [ADDR_W-1:0]   w_redir_pc;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_room;
    logic                w_valid;

    // Fetch addresses are halfword aligned. Masking bit 0 here keeps every
    // later use of redirect_pc aligned.
    assign w_redir_pc   = redirect_pc & ~ADDR_W'(1);
    assign w_addr_inc   = r_addr + ADDR_W'(2);

    assign w_valid      = (r_count != '0);
    // Any redirect suppresses the pop, because the head entry is about to be flushed.
    assign w_pop        = w_valid & instr_ready & ~redirect_valid;
    // Data returned together with a redirect belongs to the old path, so it is not pushed.
    assign w_push       = (r_state == S_REQ) & imem_ack & ~redirect_valid;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // A read is continued only if the FIFO still has room after this cycle.
    // This rule is why the FIFO can never overflow.
    assign w_room       = (w_count_next < FULL_CNT);

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign instr_valid  = w_valid;
    assign instruction  = w_valid ? r_fifo_instr[r_rd_ptr] : 16'h0000;
    assign instr_pc     = w_valid ? r_fifo_pc[r_rd_ptr]    : {ADDR_W{1'b0}};

    // ------------------------------------------------------------------
    // Fetch control FSM: state, request, address and fetch PC.
    // imem_req is registered next to the state, so it is high exactly in
    // REQ and DROP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                        r_addr     <= w_redir_pc;
                        r_state    <= S_REQ;
                        r_req      <= 1'b1;
                    end else if (r_count < FULL_CNT) begin
                        r_addr     <= r_fetch_pc;
                        r_state    <= S_REQ;
                        r_req      <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (imem_ack && redirect_valid) begin
                        // The old data is thrown away. The new read is issued on the next cycle.
                        r_fetch_pc <= w_redir_pc;
                        r_addr     <= w_redir_pc;
                    end else if (imem_ack) begin
                        // The address wraps modulo 2^ADDR_W.
                        r_fetch_pc <= w_addr_inc;
                        r_addr     <= w_addr_inc;
                        if (!w_room) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        // The read is still outstanding. Keep the address
                        // stable until it completes, and remember the new
                        // path in fetch_pc.
                        r_fetch_pc <= w_redir_pc;
                        r_state    <= S_DROP;
                    end
                end

                S_DROP: begin
                    if (imem_ack) begin
                        // If a redirect arrives together with the ack, the newest redirect target wins.
                        r_state <= S_REQ;
                        if (redirect_valid) begin
                            r_fetch_pc <= w_redir_pc;
                            r_addr     <= w_redir_pc;
                        end else begin
                            r_addr     <= r_fetch_pc;
                        end
                    end else if (redirect_valid) begin
                        r_fetch_pc <= w_redir_pc;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO control: occupancy count and read/write pointers.
    // A redirect empties the FIFO on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. The data is never reset: an entry is read only after
    // it has been written, and the outputs are gated to zero when empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_addr;
        end
    end

    // A push into a full FIFO is only legal if a pop happens in the same cycle.
    always @(posedge clk) begin
        if (reset && w_push) begin
            assert (r_count < FULL_CNT || w_pop);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// tb_ifetch_unit -- self-checking bench for ifetch_unit
//
// The main instance uses the default parameters. A second instance, with
// RESET_PC = 16'hFFFE and its memory always acking, covers address wrap.
// The directed sequences walk through the listed scenarios. After them, a
// randomized phase drives ack, ready and redirects. Those cycles are checked
// against a stream model: after reset or a redirect to P, the decoder must
// see P, P+2, P+4 ... in order, each with its memory word, and no gaps.
// ============================================================================
module tb_ifetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_rdata;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [15:0] w_pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory image: each address returns an address-derived halfword.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    ifetch_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    ifetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (1'b1),
        .imem_rdata     (w_rdata),
        .instr_valid    (w_valid),
        .instruction    (w_instr),
        .instr_pc       (w_pc),
        .instr_ready    (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (16'h0000)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: inputs set before the call are seen by the next
    // rising edge, and outputs are sampled on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic hold_reset();
        reset          = 1'b0;
        imem_ack       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_until_addr(input logic [15:0] target);
        for (int i = 0; i < 40 && !(imem_req && imem_addr == target); i++) tick();
        chk("reach_addr", imem_addr, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_pc;
        logic        prev_req;
        logic        prev_ack;
        logic [15:0] prev_addr;
        logic        chk_flush;
        int          pops;

        // ---------------- reset values and streaming at one per cycle --------
        hold_reset();
        chk("rst_req",   16'(imem_req), 16'd0);
        chk("rst_addr",  imem_addr, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_pc",    instr_pc, 16'h0000);
        chk("rst_waddr", w_addr, 16'hFFFE);
        chk("rst_wreq",  16'(w_req), 16'd0);

        instr_ready = 1'b1;
        imem_ack    = 1'b1;
        reset       = 1'b1;
        chk("req_before_edge", 16'(imem_req), 16'd0);
        tick();
        chk("first_req",  16'(imem_req), 16'd1);
        chk("first_addr", imem_addr, 16'h0000);
        chk("wrap_addr0", w_addr, 16'hFFFE);
        tick();
        chk("wrap_addr1", w_addr, 16'h0000);
        chk("wrap_pc0",   w_pc, 16'hFFFE);
        chk("wrap_ins0",  w_instr, mem_word(16'hFFFE));
        for (int k = 0; k < 10; k++) begin
            if (k == 1) chk("wrap_pc1", w_pc, 16'h0000);
            chk("s_valid", 16'(instr_valid), 16'd1);
            chk("s_pc",    instr_pc, 16'(2 * k));
            chk("s_instr", instruction, mem_word(16'(2 * k)));
            chk("s_addr",  imem_addr, 16'(2 * k + 2));
            tick();
        end

        // ---------------- FIFO fills, then one pop triggers one fetch --------
        hold_reset();
        imem_ack = 1'b1;
        reset    = 1'b1;
        repeat (5) tick();
        chk("full_req",   16'(imem_req), 16'd0);
        chk("full_valid", 16'(instr_valid), 16'd1);
        chk("full_pc",    instr_pc, 16'h0000);
        chk("full_instr", instruction, mem_word(16'h0000));
        repeat (2) tick();
        chk("full_req2",  16'(imem_req), 16'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pop1_pc",    instr_pc, 16'h0002);
        chk("pop1_req",   16'(imem_req), 16'd0);
        tick();
        chk("refetch_req",  16'(imem_req), 16'd1);
        chk("refetch_addr", imem_addr, 16'h0008);
        tick();
        chk("refill_req", 16'(imem_req), 16'd0);
        chk("refill_pc",  instr_pc, 16'h0002);

        // ---------------- redirect while a read is outstanding ----------------
        hold_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        reset       = 1'b1;
        run_until_addr(16'h0010);
        imem_ack = 1'b0;
        tick();
        chk("drop_pre_valid", 16'(instr_valid), 16'd0);
        chk("drop_pre_addr",  imem_addr, 16'h0010);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0101;
        tick();
        redirect_valid = 1'b0;
        chk("drop_req",   16'(imem_req), 16'd1);
        chk("drop_addr",  imem_addr, 16'h0010);
        chk("drop_valid", 16'(instr_valid), 16'd0);
        tick();
        chk("drop_addr2", imem_addr, 16'h0010);
        imem_ack = 1'b1;
        tick();
        chk("drop_after_valid", 16'(instr_valid), 16'd0);
        chk("drop_after_req",   16'(imem_req), 16'd1);
        chk("drop_after_addr",  imem_addr, 16'h0100);
        tick();
        chk("redir_valid", 16'(instr_valid), 16'd1);
        chk("redir_pc",    instr_pc, 16'h0100);
        chk("redir_instr", instruction, mem_word(16'h0100));

        // ---------------- redirect in the same cycle as an ack ----------------
        hold_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        reset       = 1'b1;
        run_until_addr(16'h0008);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        chk("ackredir_req",   16'(imem_req), 16'd1);
        chk("ackredir_addr",  imem_addr, 16'h0040);
        chk("ackredir_valid", 16'(instr_valid), 16'd0);
        tick();
        chk("ackredir_pc",    instr_pc, 16'h0040);
        chk("ackredir_instr", instruction, mem_word(16'h0040));

        // ---------------- asynchronous reset in mid-stream --------------------
        hold_reset();
        imem_ack = 1'b1;
        reset    = 1'b1;
        repeat (4) tick();
        imem_ack = 1'b0;
        chk("mid_pre_req",  16'(imem_req), 16'd1);
        chk("mid_pre_addr", imem_addr, 16'h0006);
        chk("mid_pre_pc",   instr_pc, 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req",   16'(imem_req), 16'd0);
        chk("mid_rst_addr",  imem_addr, 16'h0000);
        chk("mid_rst_valid", 16'(instr_valid), 16'd0);
        chk("mid_rst_instr", instruction, 16'h0000);
        chk("mid_rst_pc",    instr_pc, 16'h0000);
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        reset    = 1'b1;
        tick();
        chk("mid_rel_req",   16'(imem_req), 16'd1);
        chk("mid_rel_addr",  imem_addr, 16'h0000);
        chk("mid_rel_valid", 16'(instr_valid), 16'd0);
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("mid_rel_pvalid", 16'(instr_valid), 16'd1);
        chk("mid_rel_instr",  instruction, mem_word(16'h0000));
        tick();
        chk("mid_rel_pc2",    instr_pc, 16'h0002);

        // ---------------- randomized run against the stream model -------------
        hold_reset();
        reset     = 1'b1;
        exp_pc    = 16'h0000;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 16'h0000;
        chk_flush = 1'b0;
        pops      = 0;
        for (int c = 0; c < 4000; c++) begin
            if (chk_flush) chk("r_flush_valid", 16'(instr_valid), 16'd0);
            if (prev_req && !prev_ack) begin
                chk("r_req_hold",  16'(imem_req), 16'd1);
                chk("r_addr_hold", imem_addr, prev_addr);
            end
            if (!instr_valid) begin
                chk("r_empty_instr", instruction, 16'h0000);
                chk("r_empty_pc",    instr_pc, 16'h0000);
            end

            instr_ready    = ($urandom_range(0, 3) != 0);
            imem_ack       = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = 16'($urandom);

            if (redirect_valid) begin
                exp_pc    = redirect_pc & 16'hFFFE;
                chk_flush = 1'b1;
            end else begin
                chk_flush = 1'b0;
                if (instr_valid && instr_ready) begin
                    chk("r_pc",    instr_pc, exp_pc);
                    chk("r_instr", instruction, mem_word(exp_pc));
                    exp_pc = exp_pc + 16'd2;
                    pops++;
                end
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            tick();
        end
        chk("r_progress", 16'(pops > 200), 16'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
